// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM stage and a CGRA.
//
// Only the IDLE state arbitrates. The winner's address, data and write enable are latched into
// the mem_* registers and presented with mem_req_o until mem_ready_i. The returned data goes
// into the owner's rdata register. Every access then spends one cycle in a DONE state before
// the FSM returns to IDLE.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   cpu_memread_i/_we     MEM-stage load/store request (both high = store)
//   cpu_addr_i/wdata_i    MEM-stage address / store data
//   cpu_rdata_o           registered load data
//   stall_o               pipeline stall (combinational)
//   cgra_req_i            CGRA request level, held until cgra_done_o
//   cgra_we/addr/wdata_i  CGRA access attributes
//   cgra_rdata_o          registered CGRA read data
//   cgra_done_o           one-cycle completion pulse
//   mem_req/we/addr/wdata_o, mem_rdata_i, mem_ready_i   data-memory port
//
// Configuration
//   DMEM_ARB_RR_EN  defined: round-robin between CPU and CGRA using a last-owner register.
//                   undefined: fixed priority, the CPU always wins.
module dmem_arbiter #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_memread_i,
    input  logic          cpu_memwrite_i,
    input  logic [DW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          stall_o,
    input  logic          cgra_req_i,
    input  logic          cgra_we_i,
    input  logic [DW-1:0] cgra_addr_i,
    input  logic [DW-1:0] cgra_wdata_i,
    output logic [DW-1:0] cgra_rdata_o,
    output logic          cgra_done_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StCpuAcc   = 3'd1;
    localparam logic [2:0] StCgraAcc  = 3'd2;
    localparam logic [2:0] StCpuDone  = 3'd3;
    localparam logic [2:0] StCgraDone = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          cpu_pend;
    logic          grant_cpu, grant_cgra;
    logic          mem_we_q;
    logic [DW-1:0] mem_addr_q, mem_wdata_q;
    logic [DW-1:0] cpu_rdata_q, cgra_rdata_q;

    assign cpu_pend = cpu_memread_i | cpu_memwrite_i;

`ifdef DMEM_ARB_RR_EN
    // Set when the CGRA held the most recent grant; reset favours the CPU first.
    logic last_cgra_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_cgra_q <= 1'b1;
        end else if (state_q == StIdle && (grant_cpu || grant_cgra)) begin
            last_cgra_q <= grant_cgra;
        end
    end

    assign grant_cpu = cpu_pend & (~cgra_req_i | last_cgra_q);
`else
    assign grant_cpu = cpu_pend;
`endif
    assign grant_cgra = cgra_req_i & ~grant_cpu;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_cpu) begin
                    state_d = StCpuAcc;
                end else if (grant_cgra) begin
                    state_d = StCgraAcc;
                end
            end
            StCpuAcc:   if (mem_ready_i) state_d = StCpuDone;
            StCgraAcc:  if (mem_ready_i) state_d = StCgraDone;
            // DONE never re-arbitrates, so a requester seen here is not double-served.
            StCpuDone:  state_d = StIdle;
            StCgraDone: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            cgra_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                if (grant_cpu) begin
                    // A simultaneous read+write request is a store.
                    mem_we_q    <= cpu_memwrite_i;
                    mem_addr_q  <= cpu_addr_i;
                    mem_wdata_q <= cpu_wdata_i;
                end else if (grant_cgra) begin
                    mem_we_q    <= cgra_we_i;
                    mem_addr_q  <= cgra_addr_i;
                    mem_wdata_q <= cgra_wdata_i;
                end
            end
            if (mem_ready_i && state_q == StCpuAcc) begin
                cpu_rdata_q <= mem_rdata_i;
            end
            if (mem_ready_i && state_q == StCgraAcc) begin
                cgra_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o    = (state_q == StCpuAcc) || (state_q == StCgraAcc);
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign cgra_rdata_o = cgra_rdata_q;
    assign cgra_done_o  = (state_q == StCgraDone);
    // CPU_DONE releases the pipeline so the served instruction leaves MEM.
    assign stall_o      = ~rst_i & cpu_pend & (state_q != StCpuDone);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter. Stimulus pushes the expected memory transactions in
// grant order; a monitor checks each presented access and the following DONE cycle.
module tb_dmem_arbiter;

    localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic          cpu_memread_i, cpu_memwrite_i;
    logic [DW-1:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic          stall_o;
    logic          cgra_req_i, cgra_we_i;
    logic [DW-1:0] cgra_addr_i, cgra_wdata_i, cgra_rdata_o;
    logic          cgra_done_o;
    logic          mem_req_o, mem_we_o;
    logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic          mem_ready_i;

    dmem_arbiter #(.DW(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cpu_memread_i (cpu_memread_i),
        .cpu_memwrite_i(cpu_memwrite_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_wdata_i   (cpu_wdata_i),
        .cpu_rdata_o   (cpu_rdata_o),
        .stall_o       (stall_o),
        .cgra_req_i    (cgra_req_i),
        .cgra_we_i     (cgra_we_i),
        .cgra_addr_i   (cgra_addr_i),
        .cgra_wdata_i  (cgra_wdata_i),
        .cgra_rdata_o  (cgra_rdata_o),
        .cgra_done_o   (cgra_done_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ready_i   (mem_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          cgra;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          done_count = 0;
    int          resp_lat = 0;
    logic [31:0] resp_data = '0;
    int          base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input bit cgra, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        exp_t e;
        e.cgra = cgra; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
        sb.push_back(e);
    endtask

    // Drive a CPU access and return in its CPU_DONE cycle (first cycle with stall_o low).
    task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
        int n;
        cpu_memread_i = rd; cpu_memwrite_i = wr; cpu_addr_i = addr; cpu_wdata_i = wdata;
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (stall_o && n < 60);
        check("cpu_stall_release", {31'b0, stall_o}, 32'd0);
    endtask

    task automatic cpu_idle();
        cpu_memread_i = 1'b0; cpu_memwrite_i = 1'b0;
    endtask

    // Hold a CGRA request until cgra_done_o, then drop it in the done cycle.
    task automatic cgra_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input bit chk_stall);
        int n;
        cgra_req_i = 1'b1; cgra_we_i = we; cgra_addr_i = addr; cgra_wdata_i = wdata;
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
            if (chk_stall) check("cgra_stall_low", {31'b0, stall_o}, 32'd0);
        end while (!cgra_done_o && n < 60);
        check("cgra_access_done", {31'b0, cgra_done_o}, 32'd1);
        cgra_req_i = 1'b0; cgra_we_i = 1'b0;
    endtask

    // Memory model: ready after resp_lat wait cycles of mem_req_o.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_ready_i = 1'b0;
            if (mem_req_o === 1'b1) begin
                if (cnt >= resp_lat) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = resp_data;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks the presented access against the scoreboard head, then its DONE cycle.
    initial begin
        exp_t cur;
        exp_t last;
        bit   pend;
        int   req_cycles;
        pend = 1'b0;
        req_cycles = 0;
        forever begin
            @(negedge clk); #1;
            if (pend) begin
                pend = 1'b0;
                if (last.cgra) begin
                    check("cgra_done_pulse", {31'b0, cgra_done_o}, 32'd1);
                    check("cgra_rdata", cgra_rdata_o, last.rdata);
                end else begin
                    check("cpu_done_stall", {31'b0, stall_o}, 32'd0);
                    check("cpu_rdata", cpu_rdata_o, last.rdata);
                    check("cgra_done_quiet", {31'b0, cgra_done_o}, 32'd0);
                end
            end else begin
                check("cgra_done_quiet", {31'b0, cgra_done_o}, 32'd0);
            end
            if (mem_req_o === 1'b1) begin
                req_cycles++;
                if (sb.size() > 0) begin
                    cur = sb[0];
                    check("mem_we", {31'b0, mem_we_o}, {31'b0, cur.we});
                    check("mem_addr", mem_addr_o, cur.addr);
                    check("mem_wdata", mem_wdata_o, cur.wdata);
                end
                if (mem_ready_i) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_access: got addr 0x%08h, expected none",
                                 mem_addr_o);
                    end else begin
                        cur = sb.pop_front();
                        check("req_cycles", req_cycles, cur.lat + 1);
                        last = cur;
                        pend = 1'b1;
                        done_count++;
                    end
                    req_cycles = 0;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cpu_memread_i = 1'b1; cpu_memwrite_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        cgra_req_i = 1'b0; cgra_we_i = 1'b0; cgra_addr_i = '0; cgra_wdata_i = '0;

        // Reset state; stall forced low even with a CPU request present.
        repeat (2) @(negedge clk);
        #2;
        check("rst_stall_forced", {31'b0, stall_o}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_cpu_rdata", cpu_rdata_o, 32'd0);
        check("rst_cgra_rdata", cgra_rdata_o, 32'd0);
        check("rst_cgra_done", {31'b0, cgra_done_o}, 32'd0);
        cpu_idle();
        rst = 1'b0;

        // CPU load, ready immediately: stall 1,1,0.
        resp_lat = 0; resp_data = 32'hDEADBEEF;
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        @(negedge clk);
        cpu_memread_i = 1'b1; cpu_addr_i = 32'h100; cpu_wdata_i = 32'h0;
        #2;
        check("t1_stall_c0", {31'b0, stall_o}, 32'd1);
        @(negedge clk); #2;
        check("t1_stall_c1", {31'b0, stall_o}, 32'd1);
        check("t1_req_c1", {31'b0, mem_req_o}, 32'd1);
        @(negedge clk); #2;
        check("t1_stall_c2", {31'b0, stall_o}, 32'd0);
        check("t1_req_c2", {31'b0, mem_req_o}, 32'd0);
        check("t1_cpu_rdata", cpu_rdata_o, 32'hDEADBEEF);
        cpu_idle();

        // CGRA write, three access cycles, no stall.
        resp_lat = 2; resp_data = 32'h0BADF00D;
        push(1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0BADF00D, 2);
        repeat (2) @(negedge clk);
        cgra_access(1'b1, 32'h40, 32'h12345678, 1'b1);
        @(negedge clk); #2;
        check("t2_addr_hold", mem_addr_o, 32'h40);
        check("t2_req_idle", {31'b0, mem_req_o}, 32'd0);

        // Both pending from reset; CPU store follows its load.
        rst = 1'b1;
        cpu_memread_i = 1'b1; cpu_addr_i = 32'h200; cpu_wdata_i = 32'h0;
        cgra_req_i = 1'b1; cgra_we_i = 1'b0; cgra_addr_i = 32'h300; cgra_wdata_i = 32'h0;
        resp_lat = 1; resp_data = 32'h11112222;
        push(1'b0, 1'b0, 32'h200, 32'h0, 32'h11112222, 1);
        if (RR) begin
            push(1'b1, 1'b0, 32'h300, 32'h0, 32'h11112222, 1);
            push(1'b0, 1'b1, 32'h204, 32'hCAFE0001, 32'h11112222, 1);
        end else begin
            push(1'b0, 1'b1, 32'h204, 32'hCAFE0001, 32'h11112222, 1);
            push(1'b1, 1'b0, 32'h300, 32'h0, 32'h11112222, 1);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        base = done_count;
        fork
            begin
                cpu_access(1'b1, 1'b0, 32'h200, 32'h0);
                cpu_access(1'b0, 1'b1, 32'h204, 32'hCAFE0001);
                check("t3_store_order", done_count - base, RR ? 32'd3 : 32'd2);
                check("t3_store_we", {31'b0, mem_we_o}, 32'd1);
                check("t3_store_addr", mem_addr_o, 32'h204);
                cpu_idle();
            end
            cgra_access(1'b0, 32'h300, 32'h0, 1'b0);
        join
        repeat (3) @(negedge clk);

        // CPU requests three accesses back to back while the CGRA waits.
        rst = 1'b1;
        cpu_memread_i = 1'b1; cpu_addr_i = 32'h500;
        cgra_req_i = 1'b1; cgra_we_i = 1'b1; cgra_addr_i = 32'h600; cgra_wdata_i = 32'h55AA55AA;
        resp_lat = 0; resp_data = 32'h33334444;
        push(1'b0, 1'b0, 32'h500, 32'h0, 32'h33334444, 0);
        if (RR) push(1'b1, 1'b1, 32'h600, 32'h55AA55AA, 32'h33334444, 0);
        push(1'b0, 1'b0, 32'h504, 32'h0, 32'h33334444, 0);
        push(1'b0, 1'b0, 32'h508, 32'h0, 32'h33334444, 0);
        if (!RR) push(1'b1, 1'b1, 32'h600, 32'h55AA55AA, 32'h33334444, 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        base = done_count;
        fork
            begin
                cpu_access(1'b1, 1'b0, 32'h500, 32'h0);
                cpu_access(1'b1, 1'b0, 32'h504, 32'h0);
                cpu_access(1'b1, 1'b0, 32'h508, 32'h0);
                check("t4_cpu_run", done_count - base, RR ? 32'd4 : 32'd3);
                cpu_idle();
            end
            cgra_access(1'b1, 32'h600, 32'h55AA55AA, 1'b0);
        join
        repeat (3) @(negedge clk);

        // Reset during a CGRA access abandons it.
        resp_lat = 0; resp_data = 32'h00000077;
        push(1'b1, 1'b0, 32'h80, 32'h0, 32'h00000077, 0);
        cgra_access(1'b0, 32'h80, 32'h0, 1'b0);
        resp_lat = 10;
        cgra_req_i = 1'b1; cgra_addr_i = 32'h84;
        @(negedge clk); #2;
        @(negedge clk); #2;
        check("t5_in_acc", {31'b0, mem_req_o}, 32'd1);
        check("t5_rdata_before", cgra_rdata_o, 32'h77);
        rst = 1'b1;
        @(negedge clk); #2;
        check("t5_req_dropped", {31'b0, mem_req_o}, 32'd0);
        check("t5_no_done", {31'b0, cgra_done_o}, 32'd0);
        check("t5_rdata_cleared", cgra_rdata_o, 32'd0);
        cgra_req_i = 1'b0;
        rst = 1'b0;
        @(negedge clk); #2;
        check("t5_no_late_done", {31'b0, cgra_done_o}, 32'd0);

        // Read and write both asserted is a store.
        resp_lat = 0; resp_data = 32'h5A5A5A5A;
        push(1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, 32'h5A5A5A5A, 0);
        cpu_access(1'b1, 1'b1, 32'h10, 32'hA1B2C3D4);
        check("t6_both_is_write", {31'b0, mem_we_o}, 32'd1);
        cpu_idle();

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
